// File: rtl/lenet_feed_pkg.sv
// Shared constants and state types for the LeNet frame feeder.
package lenet_feed_pkg;

    localparam int NPIX = 1024;   // 32x32 pixels per frame
    localparam int AW   = 10;     // pixel address width

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN
    } feed_st_t;

    typedef enum logic {
        EMPTY,
        FULL
    } bank_st_t;

endpackage

// File: rtl/lenet_frame_feeder_if.sv
// Bundles the ingress stream, lenet core handshake/read port and result port.
interface lenet_frame_feeder_if #(
    parameter int DW    = 32,
    parameter int PIX_W = 8,
    parameter int AW    = 10
);
    logic             s_valid;
    logic [PIX_W-1:0] s_data;
    logic             s_ready;
    logic             go;
    logic             ready;
    logic [3:0]       digit;
    logic             cena_src;
    logic [AW-1:0]    aa_src;
    logic [DW-1:0]    qa_src;
    logic             res_valid;
    logic [3:0]       res_digit;
    logic             res_ready;
    logic [31:0]      frame_cnt;

    // Environment side: pixel source, lenet core and result consumer.
    modport master (
        output s_valid, s_data, ready, digit, cena_src, aa_src, res_ready,
        input  s_ready, go, qa_src, res_valid, res_digit, frame_cnt
    );

    // Feeder side.
    modport slave (
        input  s_valid, s_data, ready, digit, cena_src, aa_src, res_ready,
        output s_ready, go, qa_src, res_valid, res_digit, frame_cnt
    );
endinterface

// File: rtl/feed_bank_ram.sv
// One frame bank: single write port, single registered read port.
module feed_bank_ram #(
    parameter int DEPTH = 1024,
    parameter int W     = 8,
    parameter int AW    = 10
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    // Pixel store; contents survive reset so stale reads stay harmless.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Read register holds its value while the read enable is low.
    always_ff @(posedge clk_i) begin
        if (rst_i)     rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/lenet_frame_feeder.sv
// Ping-pong frame buffer between pixel ingress and the lenet core, with the
// go/ready control handshake and a valid/ready result port.
module lenet_frame_feeder
    import lenet_feed_pkg::*;
#(
    parameter int DW    = 32,
    parameter int PIX_W = 8
) (
    input logic                  clk,
    input logic                  rst,
    lenet_frame_feeder_if.slave  bus
);
    feed_st_t         state_q, state_d;
    bank_st_t         bank_q [2];
    logic             wr_sel_q, rd_sel_q, rsel_q;
    logic [AW-1:0]    pix_cnt_q;
    logic             res_valid_q;
    logic [3:0]       res_digit_q;
    logic [31:0]      frame_cnt_q;
    logic [PIX_W-1:0] rdata [2];
    logic             accept, frame_done, release_b;

    assign bus.s_ready = (bank_q[wr_sel_q] == EMPTY);
    assign accept      = bus.s_valid && bus.s_ready;
    assign frame_done  = accept && (pix_cnt_q == AW'(NPIX - 1));
    assign release_b   = (state_q == RUN) && bus.ready;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        feed_bank_ram #(.DEPTH(NPIX), .W(PIX_W), .AW(AW)) u_ram (
            .clk_i  (clk),
            .rst_i  (rst),
            .we_i   (accept && (wr_sel_q == 1'(b))),
            .waddr_i(pix_cnt_q),
            .wdata_i(bus.s_data),
            .re_i   (!bus.cena_src),
            .raddr_i(bus.aa_src),
            .rdata_o(rdata[b])
        );
    end

    // Bank owning the last read decides which RAM output drives qa_src.
    always_ff @(posedge clk) begin
        if (rst)                rsel_q <= 1'b0;
        else if (!bus.cena_src) rsel_q <= rd_sel_q;
    end

    assign bus.qa_src = {{(DW - PIX_W){1'b0}}, rdata[rsel_q]};

    // Fill and release may hit different banks in the same cycle; both apply.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q[0] <= EMPTY;
            bank_q[1] <= EMPTY;
            wr_sel_q  <= 1'b0;
            rd_sel_q  <= 1'b0;
            pix_cnt_q <= '0;
        end else begin
            if (accept) pix_cnt_q <= frame_done ? '0 : pix_cnt_q + 1'b1;
            if (frame_done) begin
                bank_q[wr_sel_q] <= FULL;
                wr_sel_q         <= ~wr_sel_q;
            end
            if (release_b) begin
                bank_q[rd_sel_q] <= EMPTY;
                rd_sel_q         <= ~rd_sel_q;
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Start only on a full read bank with no result left unclaimed.
    always_comb begin
        state_d = state_q;
        bus.go  = 1'b0;
        unique case (state_q)
            IDLE:    if (bank_q[rd_sel_q] == FULL && !res_valid_q) state_d = START;
            START: begin
                bus.go  = 1'b1;
                state_d = RUN;
            end
            RUN:     if (bus.ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Result holding register and accepted-result counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            res_digit_q <= '0;
            frame_cnt_q <= '0;
        end else if (release_b) begin
            res_valid_q <= 1'b1;
            res_digit_q <= bus.digit;
        end else if (res_valid_q && bus.res_ready) begin
            res_valid_q <= 1'b0;
            frame_cnt_q <= frame_cnt_q + 32'd1;
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_digit = res_digit_q;
    assign bus.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_lenet_frame_feeder.sv
// Bench for lenet_frame_feeder: occupancy-level model checked every cycle
// plus directed scenarios with literal expectations.
module tb_lenet_frame_feeder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lenet_frame_feeder_if bus ();
    lenet_frame_feeder dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk = 0, n_err = 0, cyc = 0;
    int go_cnt = 0, go_cyc = 0, last_beat_cyc = 0;
    logic [3:0] got[$];

    // lenet core stand-in controls
    bit         man_mode = 1'b1, man_ready = 1'b0;
    logic [3:0] man_digit = 4'd0;
    int         lat = 1, lat_cnt = 0, next_dig = 0;

    // model state: buffered frame count, ingress position, result and read data
    int          m_nbuf = 0, m_pix = 0, m_rd = 0, m_ph = 0;
    bit          m_rv = 1'b0, m_qa_ok = 1'b1;
    logic [3:0]  m_dig = 4'd0;
    logic [31:0] m_fc = 32'd0, m_qa = 32'd0;
    logic [7:0]  m_mem [2][1024];
    bit          m_known [2][1024];
    int          nb0, ph0, wb;
    bit          rv0, fill;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int a);
        bus.cena_src = 1'b0;
        bus.aa_src   = 10'(a);
        step();
        bus.cena_src = 1'b1;
    endtask

    task automatic send_frame(input int mul, input int add, input int abort_at);
        int w;
        for (int i = 0; i < 1024; i++) begin
            if (i == abort_at) begin
                bus.s_valid = 1'b0;
                rst = 1'b1;
                step();
                rst = 1'b0;
                return;
            end
            bus.s_valid = 1'b1;
            bus.s_data  = 8'((i * mul + add) % 251);
            w = 0;
            while (!bus.s_ready && w < 3000) begin
                step();
                w++;
            end
            if (!bus.s_ready) begin
                chk("ingress_stall_timeout", 64'd0, 64'd1);
                bus.s_valid = 1'b0;
                return;
            end
            last_beat_cyc = cyc;
            step();
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_res(input int bound, input string nm);
        int w;
        w = 0;
        while (!bus.res_valid && w < bound) begin
            step();
            w++;
        end
        if (!bus.res_valid) chk(nm, 64'd0, 64'd1);
    endtask

    // lenet stand-in: manual drive, or ready+digit 'lat' cycles after each go
    initial begin
        bus.ready = 1'b0;
        bus.digit = 4'd0;
        forever begin
            @(posedge clk);
            #2;
            if (man_mode) begin
                bus.ready = man_ready;
                bus.digit = man_digit;
            end else begin
                bus.ready = 1'b0;
                if (lat_cnt > 0) begin
                    lat_cnt--;
                    if (lat_cnt == 0) begin
                        bus.ready = 1'b1;
                        bus.digit = next_dig[3:0];
                        next_dig++;
                    end
                end
                if (bus.go) lat_cnt = lat;
            end
        end
    end

    // Model: frames buffered (0..2), result slot, and read data per bank.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_nbuf = 0; m_pix = 0; m_rd = 0; m_ph = 0;
            m_rv = 1'b0; m_dig = 4'd0; m_fc = 32'd0; m_qa = 32'd0; m_qa_ok = 1'b1;
        end else begin
            nb0 = m_nbuf; ph0 = m_ph; rv0 = m_rv; fill = 1'b0;
            if (!bus.cena_src) begin
                m_qa_ok = m_known[m_rd][bus.aa_src];
                m_qa    = {24'd0, m_mem[m_rd][bus.aa_src]};
            end
            if (bus.s_valid && nb0 < 2) begin
                wb = (m_rd + nb0) % 2;
                m_mem[wb][m_pix]   = bus.s_data;
                m_known[wb][m_pix] = 1'b1;
                if (m_pix == 1023) begin
                    m_pix = 0;
                    fill  = 1'b1;
                end else m_pix++;
            end
            if (rv0 && bus.res_ready) begin
                m_rv = 1'b0;
                m_fc++;
            end
            case (ph0)
                0:       if (nb0 > 0 && !rv0) m_ph = 1;
                1:       m_ph = 2;
                default: if (bus.ready) begin
                    m_ph = 0; m_rv = 1'b1; m_dig = bus.digit; m_rd ^= 1; m_nbuf--;
                end
            endcase
            if (fill) m_nbuf++;
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("s_ready", bus.s_ready, m_nbuf < 2);
            chk("go", bus.go, m_ph == 1);
            chk("res_valid", bus.res_valid, m_rv);
            chk("res_digit", bus.res_digit, m_dig);
            chk("frame_cnt", bus.frame_cnt, m_fc);
            if (m_qa_ok) chk("qa_src", bus.qa_src, m_qa);
            if (bus.go) begin
                go_cnt++;
                go_cyc = cyc;
            end
            if (bus.res_valid && bus.res_ready) got.push_back(bus.res_digit);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err + 1);
        $fatal(1);
    end

    initial begin
        bit found;
        rst = 1'b1;
        bus.s_valid = 1'b0; bus.s_data = 8'd0; bus.cena_src = 1'b1;
        bus.aa_src = 10'd0; bus.res_ready = 1'b0;
        repeat (3) step();
        chk("rst_s_ready", bus.s_ready, 1);
        chk("rst_go", bus.go, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_frame_cnt", bus.frame_cnt, 0);
        chk("rst_qa", bus.qa_src, 0);
        rst = 1'b0;

        // frame of i%251, go timing, reads; lenet answers 7 after 300 cycles
        man_mode = 1'b0; lat = 300; next_dig = 7; bus.res_ready = 1'b1;
        send_frame(1, 0, -1);
        repeat (4) step();
        chk("t1_go_count", go_cnt, 1);
        chk("t1_go_latency", go_cyc - last_beat_cyc, 2);
        rd(5);
        chk("t1_qa_addr5", bus.qa_src, 5);
        rd(300);
        chk("t1_qa_addr300", bus.qa_src, 49);
        wait_res(400, "t2_result_timeout");
        chk("t2_res_digit", bus.res_digit, 7);
        step();
        chk("t2_res_valid_one_cycle", bus.res_valid, 0);
        chk("t2_frame_cnt", bus.frame_cnt, 1);

        // three frames, consumer stalled, slow lenet
        bus.res_ready = 1'b0; lat = 1500; next_dig = 1; got.delete();
        send_frame(1, 1, -1);
        send_frame(1, 2, -1);
        chk("t3_s_ready_low", bus.s_ready, 0);
        send_frame(1, 3, -1);
        bus.res_ready = 1'b1;
        for (int w = 0; w < 5000 && got.size() < 3; w++) step();
        chk("t3_n_results", got.size(), 3);
        for (int k = 0; k < 3; k++)
            chk($sformatf("t3_digit%0d", k), (k < got.size()) ? got[k] : 4'd15, k + 1);
        step();
        chk("t3_frame_cnt", bus.frame_cnt, 4);

        // ready in IDLE and during START is ignored
        man_mode = 1'b1; man_ready = 1'b1; man_digit = 4'd2;
        repeat (3) step();
        chk("t4_idle_ready_no_result", bus.res_valid, 0);
        man_ready = 1'b0;
        send_frame(1, 4, -1);
        found = 1'b0;
        for (int w = 0; w < 10; w++) begin
            if (bus.go) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("t4_go_seen", found, 1);
        man_ready = 1'b1; man_digit = 4'd5;
        step();
        man_ready = 1'b0;
        repeat (4) step();
        chk("t4_start_ready_no_result", bus.res_valid, 0);
        chk("t4_no_restart", go_cnt, 5);
        man_ready = 1'b1; man_digit = 4'd9;
        step();
        man_ready = 1'b0;
        chk("t4_run_ready_valid", bus.res_valid, 1);
        chk("t4_run_ready_digit", bus.res_digit, 9);
        repeat (2) step();
        chk("t4_frame_cnt", bus.frame_cnt, 5);

        // reset mid-frame while another frame runs
        send_frame(1, 5, -1);
        repeat (5) step();
        send_frame(1, 6, 600);
        chk("t5_go_after_rst", bus.go, 0);
        chk("t5_res_valid_after_rst", bus.res_valid, 0);
        chk("t5_s_ready_after_rst", bus.s_ready, 1);
        chk("t5_frame_cnt_after_rst", bus.frame_cnt, 0);
        man_mode = 1'b0; lat = 20; next_dig = 3; bus.res_ready = 1'b1;
        send_frame(7, 0, -1);
        rd(0);
        chk("t5_qa_addr0", bus.qa_src, 0);
        rd(1023);
        chk("t5_qa_addr1023", bus.qa_src, 133);

        // qa holds while cena_src is high
        bus.aa_src = 10'd5;
        step();
        bus.aa_src = 10'd77;
        step();
        chk("t6_qa_hold", bus.qa_src, 133);

        wait_res(100, "t5_result_timeout");
        chk("t5_res_digit", bus.res_digit, 3);
        step();
        chk("t5_frame_cnt", bus.frame_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
